// File: rtl/morse_tx.sv
// Morse keyer draining a byte FIFO: pops one ASCII char at a time and keys
// letters, digits and word spaces with standard unit timing.
module morse_tx #(
    parameter int WORD_BITS  = 8,
    parameter int UNIT_TICKS = 5_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 empty,
    input  logic [WORD_BITS-1:0] rdata,
    output logic                 read,
    output logic                 key,
    output logic                 busy
);
    localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(UNIT_TICKS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, MARK, SPACE, GAP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick;
    logic [2:0]    units, unit_val;
    logic [2:0]    elem_idx;
    logic [2:0]    code_len;
    logic [4:0]    code_pat;
    logic          unit_ld, idx_clr, idx_inc, code_ld;
    logic          strobe, last_unit, cur_dash;
    logic [6:0]    ch;
    logic [7:0]    rom_out;
    logic          unused_hi;

    assign unused_hi = ^rdata[WORD_BITS-1:7];

    // ROM word: {length[2:0], pattern[4:0]}, first element in bit 4, 1 = dash.
    // Length 0 means the character is not keyable.
    function automatic logic [7:0] rom(input logic [6:0] c);
        case (c)
            7'h41: rom = {3'd2, 5'b01000}; // A
            7'h42: rom = {3'd4, 5'b10000};
            7'h43: rom = {3'd4, 5'b10100};
            7'h44: rom = {3'd3, 5'b10000};
            7'h45: rom = {3'd1, 5'b00000};
            7'h46: rom = {3'd4, 5'b00100};
            7'h47: rom = {3'd3, 5'b11000};
            7'h48: rom = {3'd4, 5'b00000};
            7'h49: rom = {3'd2, 5'b00000};
            7'h4a: rom = {3'd4, 5'b01110};
            7'h4b: rom = {3'd3, 5'b10100};
            7'h4c: rom = {3'd4, 5'b01000};
            7'h4d: rom = {3'd2, 5'b11000};
            7'h4e: rom = {3'd2, 5'b10000};
            7'h4f: rom = {3'd3, 5'b11100};
            7'h50: rom = {3'd4, 5'b01100};
            7'h51: rom = {3'd4, 5'b11010};
            7'h52: rom = {3'd3, 5'b01000};
            7'h53: rom = {3'd3, 5'b00000};
            7'h54: rom = {3'd1, 5'b10000};
            7'h55: rom = {3'd3, 5'b00100};
            7'h56: rom = {3'd4, 5'b00010};
            7'h57: rom = {3'd3, 5'b01100};
            7'h58: rom = {3'd4, 5'b10010};
            7'h59: rom = {3'd4, 5'b10110};
            7'h5a: rom = {3'd4, 5'b11000}; // Z
            7'h30: rom = {3'd5, 5'b11111}; // 0
            7'h31: rom = {3'd5, 5'b01111};
            7'h32: rom = {3'd5, 5'b00111};
            7'h33: rom = {3'd5, 5'b00011};
            7'h34: rom = {3'd5, 5'b00001};
            7'h35: rom = {3'd5, 5'b00000};
            7'h36: rom = {3'd5, 5'b10000};
            7'h37: rom = {3'd5, 5'b11000};
            7'h38: rom = {3'd5, 5'b11100};
            7'h39: rom = {3'd5, 5'b11110}; // 9
            default: rom = 8'd0;
        endcase
    endfunction

    always_comb begin
        ch = rdata[6:0];
        if (ch >= 7'h61 && ch <= 7'h7a)
            ch = ch - 7'h20;
    end

    assign rom_out   = rom(ch);
    assign strobe    = (tick == TICK_MAX);
    assign last_unit = strobe && (units == 3'd1);
    assign cur_dash  = code_pat[3'd4 - elem_idx];

    always_comb begin
        state_nxt = state;
        unit_ld   = 1'b0;
        unit_val  = 3'd0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        code_ld   = 1'b0;
        case (state)
            IDLE:  if (!empty) state_nxt = FETCH;
            FETCH: state_nxt = LOAD;
            LOAD: begin
                idx_clr = 1'b1;
                if (rom_out[7:5] != 3'd0) begin
                    state_nxt = MARK;
                    code_ld   = 1'b1;
                    unit_ld   = 1'b1;
                    unit_val  = rom_out[4] ? 3'd3 : 3'd1;
                end else if (ch == 7'h20) begin
                    state_nxt = GAP;
                    unit_ld   = 1'b1;
                    unit_val  = 3'd4;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MARK: if (last_unit) begin
                unit_ld = 1'b1;
                if (elem_idx + 3'd1 < code_len) begin
                    state_nxt = SPACE;
                    idx_inc   = 1'b1;
                    unit_val  = 3'd1;
                end else begin
                    state_nxt = GAP;
                    unit_val  = 3'd3;
                end
            end
            // elem_idx already points at the next element here
            SPACE: if (last_unit) begin
                state_nxt = MARK;
                unit_ld   = 1'b1;
                unit_val  = cur_dash ? 3'd3 : 3'd1;
            end
            GAP:   if (last_unit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tick     <= '0;
            units    <= 3'd0;
            elem_idx <= 3'd0;
            code_len <= 3'd0;
            code_pat <= 5'd0;
        end else begin
            state <= state_nxt;
            // every state entry restarts unit timing from a clean boundary
            if (state_nxt != state || strobe)
                tick <= '0;
            else
                tick <= tick + 1'b1;
            if (unit_ld)
                units <= unit_val;
            else if (strobe && units != 3'd0)
                units <= units - 3'd1;
            if (idx_clr)
                elem_idx <= 3'd0;
            else if (idx_inc)
                elem_idx <= elem_idx + 3'd1;
            if (code_ld) begin
                code_len <= rom_out[7:5];
                code_pat <= rom_out[4:0];
            end
        end
    end

    assign read = (state == FETCH);
    assign key  = (state == MARK);
    assign busy = (state != IDLE);

endmodule
